// File: rtl/tmds_video_timing_if.sv
// tmds_video_timing_if: word stream in, recovered timing out.
// master drives the TMDS words, slave is the timing block.
interface tmds_video_timing_if #(
  parameter int CW = 12
);
  logic          in_valid;
  logic [29:0]   in_tmds;
  logic [23:0]   in_pix;
  logic          out_pvalid;
  logic          out_vsync;
  logic          out_hsync;
  logic [23:0]   out_pix;
  logic [CW-1:0] h_active;
  logic [CW-1:0] v_active;
  logic [15:0]   frame_cnt;
  logic          locked;

  modport master (
    output in_valid, in_tmds, in_pix,
    input  out_pvalid, out_vsync, out_hsync, out_pix,
    input  h_active, v_active, frame_cnt, locked
  );

  modport slave (
    input  in_valid, in_tmds, in_pix,
    output out_pvalid, out_vsync, out_hsync, out_pix,
    output h_active, v_active, frame_cnt, locked
  );
endinterface

// File: rtl/tmds_video_timing.sv
// tmds_video_timing: ch0 token/guard decode, sync recovery, frame
// decimation, resolution measure and lock. Option: DVI_NO_GUARD_EN.
module tmds_video_timing #(
  parameter int DECIM   = 2,
  parameter int TIMEOUT = 2**24,
  parameter int CW      = 12
) (
  input logic clk,
  input logic rst,
  tmds_video_timing_if.slave vt
);

  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] CTL2 = 10'b0101010100;
  localparam logic [9:0] CTL3 = 10'b1010101011;
  localparam logic [9:0] GB   = 10'b1011001100;

  localparam logic [1:0] S_CTRL = 2'd0;
  localparam logic [1:0] S_GB1  = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;

  localparam int          TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [3:0]  PMAX = 4'(DECIM - 1);
  // With no decimation every frame passes, including the one
  // already in flight when reset is released.
  localparam logic        FP0  = (DECIM == 1);

  logic [9:0]    word;
  logic          is_ctl;
  logic          is_gb;
  logic          tok_vs;
  logic          tok_hs;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          pixel;
  logic          px;
  logic          line_end;
  logic          vs_rise;
  logic          vsync_reg;
  logic          hsync_reg;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] hcnt_nx;
  logic [CW-1:0] vcnt;
  logic [CW-1:0] vcnt_nx;
  logic [CW-1:0] line_w;
  logic [CW-1:0] line_w_nx;
  logic [3:0]    phase;
  logic [3:0]    phase_nx;
  logic          frame_pass;
  logic          fp_nx;
  logic [TW-1:0] nv_cnt;
  logic          same_res;
  logic          unused_tmds;

  assign word        = vt.in_tmds[9:0];
  assign unused_tmds = ^vt.in_tmds[29:10];

  // Classify channel 0 word: control token (with sync bits) or guard.
  always_comb begin
    is_ctl = 1'b1;
    tok_vs = 1'b0;
    tok_hs = 1'b0;
    unique case (1'b1)
      (word == CTL0): begin
        tok_vs = 1'b0;
        tok_hs = 1'b0;
      end
      (word == CTL1): begin
        tok_vs = 1'b0;
        tok_hs = 1'b1;
      end
      (word == CTL2): begin
        tok_vs = 1'b1;
        tok_hs = 1'b0;
      end
      (word == CTL3): begin
        tok_vs = 1'b1;
        tok_hs = 1'b1;
      end
      default: is_ctl = 1'b0;
    endcase
  end

  assign is_gb = (word == GB);

  // Period tracking: control, one guard seen, active video.
  always_comb begin
    state_nx = state;
    pixel    = 1'b0;
    unique case (state)
      S_CTRL: begin
        if (is_gb) begin
          state_nx = S_GB1;
        end
`ifdef DVI_NO_GUARD_EN
        else if (!is_ctl) begin
          state_nx = S_ACT;
          pixel    = 1'b1;
        end
`endif
      end
      S_GB1: begin
        if (is_gb) begin
          state_nx = S_ACT;
        end
`ifdef DVI_NO_GUARD_EN
        else if (!is_ctl) begin
          state_nx = S_ACT;
          pixel    = 1'b1;
        end
`endif
        else begin
          state_nx = S_CTRL;
        end
      end
      S_ACT: begin
        if (is_ctl) begin
          state_nx = S_CTRL;
        end else begin
          pixel = 1'b1;
        end
      end
      default: state_nx = S_CTRL;
    endcase
  end

  assign px       = vt.in_valid & pixel;
  assign line_end = vt.in_valid & (state == S_ACT) & is_ctl;
  assign vs_rise  = vt.in_valid & is_ctl & tok_vs & ~vsync_reg;

  // Line width and line count, closed out on leaving active video.
  always_comb begin
    hcnt_nx   = hcnt;
    vcnt_nx   = vcnt;
    line_w_nx = line_w;
    if (px && hcnt != CMAX) begin
      hcnt_nx = hcnt + 1'b1;
    end
    if (line_end && hcnt != '0) begin
      line_w_nx = hcnt;
      hcnt_nx   = '0;
      if (vcnt != CMAX) begin
        vcnt_nx = vcnt + 1'b1;
      end
    end
  end

  // Decimation phase advances on each new frame.
  always_comb begin
    phase_nx = (phase == PMAX) ? 4'd0 : phase + 4'd1;
    fp_nx    = vs_rise ? (phase_nx == 4'd0) : frame_pass;
  end

  assign same_res = (line_w_nx == vt.h_active) &&
                    (vcnt_nx == vt.v_active) &&
                    (line_w_nx != '0) && (vcnt_nx != '0);

  assign vt.out_hsync = hsync_reg;
  assign vt.out_vsync = vsync_reg & frame_pass;

  // Main pipeline: state, counters, sync and pixel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_CTRL;
      hcnt          <= '0;
      vcnt          <= '0;
      line_w        <= '0;
      vsync_reg     <= 1'b0;
      hsync_reg     <= 1'b0;
      phase         <= 4'd0;
      frame_pass    <= FP0;
      vt.out_pvalid <= 1'b0;
      vt.out_pix    <= '0;
      vt.h_active   <= '0;
      vt.v_active   <= '0;
      vt.frame_cnt  <= '0;
    end else begin
      vt.out_pvalid <= px & fp_nx;
      if (vt.in_valid) begin
        state      <= state_nx;
        hcnt       <= hcnt_nx;
        line_w     <= line_w_nx;
        vcnt       <= vs_rise ? '0 : vcnt_nx;
        vt.out_pix <= vt.in_pix;
        if (is_ctl) begin
          vsync_reg <= tok_vs;
          hsync_reg <= tok_hs;
        end
      end
      if (vs_rise) begin
        vt.h_active  <= line_w_nx;
        vt.v_active  <= vcnt_nx;
        vt.frame_cnt <= vt.frame_cnt + 16'd1;
        phase        <= phase_nx;
        frame_pass   <= fp_nx;
      end
    end
  end

  // Lock: stable nonzero resolution, lost on change or vsync timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      nv_cnt    <= '0;
      vt.locked <= 1'b0;
    end else if (vs_rise) begin
      nv_cnt    <= '0;
      vt.locked <= same_res;
    end else if (nv_cnt != TMAX) begin
      nv_cnt <= nv_cnt + 1'b1;
    end else begin
      vt.locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_video_timing.sv
// tb_tmds_video_timing: directed frames into a DECIM=1 and a DECIM=2
// instance fed the same word stream, checked one cycle after each word.
module tb_tmds_video_timing;

  localparam int CW  = 12;
  localparam int TMO = 400;

  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] CTL2 = 10'b0101010100;
  localparam logic [9:0] CTL3 = 10'b1010101011;
  localparam logic [9:0] GB   = 10'b1011001100;
  localparam logic [9:0] PIXW = 10'h1F0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_ok  = 0;

  always #5 clk = ~clk;

  tmds_video_timing_if #(.CW(CW)) if1 ();
  tmds_video_timing_if #(.CW(CW)) if2 ();

  tmds_video_timing #(
    .DECIM(1), .TIMEOUT(TMO), .CW(CW)
  ) dut1 (
    .clk(clk), .rst(rst), .vt(if1.slave)
  );

  tmds_video_timing #(
    .DECIM(2), .TIMEOUT(TMO), .CW(CW)
  ) dut2 (
    .clk(clk), .rst(rst), .vt(if2.slave)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic put(
    input logic        v,
    input logic [9:0]  w,
    input logic [23:0] p
  );
    if1.in_valid = v;
    if1.in_tmds  = {20'h0, w};
    if1.in_pix   = p;
    if2.in_valid = v;
    if2.in_tmds  = {20'h0, w};
    if2.in_pix   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b1, CTL0, 24'h0);
  endtask

  task automatic zero_chk(input string tag);
    check({tag, " d1 flags"},
          {if1.out_pvalid, if1.out_vsync,
           if1.out_hsync, if1.locked}, 0);
    check({tag, " d2 flags"},
          {if2.out_pvalid, if2.out_vsync,
           if2.out_hsync, if2.locked}, 0);
    check({tag, " d1 pix"}, if1.out_pix, 0);
    check({tag, " d1 h"}, if1.h_active, 0);
    check({tag, " d1 v"}, if1.v_active, 0);
    check({tag, " d1 fc"}, if1.frame_cnt, 0);
    check({tag, " d2 fc"}, if2.frame_cnt, 0);
  endtask

  task automatic send_line(
    input int         npix,
    input logic [7:0] fr,
    input logic [7:0] ln,
    input logic       p1,
    input logic       p2,
    input int         gap
  );
    logic [23:0] pv;
    put(1'b1, CTL0, 24'h0);
    check("hs lo d1", if1.out_hsync, 0);
    check("hs lo d2", if2.out_hsync, 0);
    idle(7);
    put(1'b1, GB, 24'h0);
    put(1'b1, GB, 24'h0);
    check("gb pv", {if1.out_pvalid, if2.out_pvalid}, 0);
    for (int i = 0; i < npix; i++) begin
      if (gap != 0 && i == gap) begin
        for (int g = 0; g < 3; g++) begin
          put(1'b0, CTL3, 24'hFFFFFF);
          check("gap pv",
                {if1.out_pvalid, if2.out_pvalid}, 0);
          check("gap vs d1", if1.out_vsync, 0);
        end
      end
      pv = {fr, ln, 8'(i)};
      put(1'b1, PIXW, pv);
      check("px d1", {if1.out_pvalid, if1.out_pix},
            {p1, pv});
      check("px d2", {if2.out_pvalid, if2.out_pix},
            {p2, pv});
    end
    put(1'b1, CTL1, 24'h0);
    check("eol pv", {if1.out_pvalid, if2.out_pvalid}, 0);
    check("hs hi d1", if1.out_hsync, 1);
    check("hs hi d2", if2.out_hsync, 1);
  endtask

  task automatic send_frame(
    input int         nl,
    input int         npix,
    input logic [7:0] fr,
    input logic       p1,
    input logic       p2
  );
    for (int l = 0; l < nl; l++)
      send_line(npix, fr, 8'(l), p1, p2, 0);
  endtask

  task automatic vs_edge(
    input logic [15:0]   fc,
    input logic [CW-1:0] h,
    input logic [CW-1:0] v,
    input logic          lk,
    input logic          vs2
  );
    put(1'b1, CTL2, 24'h0);
    check("vs d1", if1.out_vsync, 1);
    check("vs d2", if2.out_vsync, vs2);
    check("fc d1", if1.frame_cnt, fc);
    check("fc d2", if2.frame_cnt, fc);
    check("h d1", if1.h_active, h);
    check("v d1", if1.v_active, v);
    check("h d2", if2.h_active, h);
    check("lock d1", if1.locked, lk);
    check("lock d2", if2.locked, lk);
    for (int k = 0; k < 3; k++) put(1'b1, CTL2, 24'h0);
    idle(4);
    check("vs off",
          {if1.out_vsync, if2.out_vsync}, 0);
  endtask

  initial begin
    if1.in_valid = 1'b1;
    if1.in_tmds  = {20'h0, CTL0};
    if1.in_pix   = '0;
    if2.in_valid = 1'b1;
    if2.in_tmds  = {20'h0, CTL0};
    if2.in_pix   = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(20);
    zero_chk("idle");

    send_frame(4, 16, 8'd1, 1'b1, 1'b0);
    vs_edge(16'd1, 12'd16, 12'd4, 1'b0, 1'b0);
    send_frame(4, 16, 8'd2, 1'b1, 1'b0);
    vs_edge(16'd2, 12'd16, 12'd4, 1'b1, 1'b1);
    send_frame(4, 17, 8'd3, 1'b1, 1'b1);
    vs_edge(16'd3, 12'd17, 12'd4, 1'b0, 1'b0);
    send_frame(4, 16, 8'd4, 1'b1, 1'b0);
    vs_edge(16'd4, 12'd16, 12'd4, 1'b0, 1'b1);
    send_frame(4, 16, 8'd5, 1'b1, 1'b1);
    vs_edge(16'd5, 12'd16, 12'd4, 1'b1, 1'b0);

    idle(100);
    check("lock hold", {if1.locked, if2.locked}, 2'b11);
    idle(320);
    check("lock tmo", {if1.locked, if2.locked}, 2'b00);

    send_line(16, 8'd6, 8'd0, 1'b1, 1'b0, 0);
    send_line(16, 8'd6, 8'd1, 1'b1, 1'b0, 8);
    send_line(16, 8'd6, 8'd2, 1'b1, 1'b0, 0);
    send_line(16, 8'd6, 8'd3, 1'b1, 1'b0, 0);
    vs_edge(16'd6, 12'd16, 12'd4, 1'b1, 1'b1);

    idle(8);
    put(1'b1, GB, 24'h0);
    put(1'b1, GB, 24'h0);
    for (int i = 0; i < 5; i++)
      put(1'b1, PIXW, 24'h777000 + 24'(i));
    check("part pv",
          {if1.out_pvalid, if2.out_pvalid}, 2'b11);
    rst = 1'b1;
    put(1'b1, PIXW, 24'h777777);
    put(1'b1, PIXW, 24'h777777);
    rst = 1'b0;
    zero_chk("mid rst");

    send_frame(3, 12, 8'd7, 1'b1, 1'b0);
    vs_edge(16'd1, 12'd12, 12'd3, 1'b0, 1'b0);

    idle(4);
    put(1'b1, GB, 24'h0);
    put(1'b1, PIXW, 24'hABCDEF);
`ifdef DVI_NO_GUARD_EN
    check("gb1 px d1", {if1.out_pvalid, if1.out_pix},
          {1'b1, 24'hABCDEF});
`else
    check("gb1 px d1", {if1.out_pvalid, if1.out_pix},
          {1'b0, 24'hABCDEF});
`endif
    check("gb1 px d2", if2.out_pvalid, 0);
    put(1'b1, CTL0, 24'h0);
    check("gb1 end",
          {if1.out_pvalid, if2.out_pvalid}, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
